// File: rtl/pcie_pio_pkg.sv
// pcie_pio_pkg: address map, IRQ FSM encoding and shared constants for the PIO register bank.
package pcie_pio_pkg;
    localparam logic [12:0] ADDR_SCRATCH     = 13'd0;
    localparam logic [12:0] ADDR_RD_CNT      = 13'd1;
    localparam logic [12:0] ADDR_WR_CNT      = 13'd2;
    localparam logic [12:0] ADDR_CPL_CNT     = 13'd3;
    localparam logic [12:0] ADDR_PENDING     = 13'd4;
    localparam logic [12:0] ADDR_MASK        = 13'd5;
    localparam logic [12:0] ADDR_FORCE       = 13'd6;
    localparam logic [12:0] ADDR_OVERFLOW    = 13'd7;
    localparam logic [12:0] ADDR_STATUS_BASE = 13'd8;
    localparam logic [12:0] ADDR_CTRL_BASE   = 13'd16;
    localparam logic [31:0] FILLER           = 32'hDEADBEEF;
    localparam int          CPL_W            = 92;
    typedef enum logic [1:0] {IRQ_IDLE, IRQ_REQ, IRQ_GAP} irq_state_t;
endpackage

// File: rtl/pcie_cpl_fifo.sv
// pcie_cpl_fifo: synchronous FIFO holding read completions until pcie_tx takes them.
module pcie_cpl_fifo #(
    parameter int W     = 92,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;
    assign full  = count == CNT_W'(DEPTH);
    assign empty = count == '0;
    assign rd    = pop && !empty;
    // a pop frees the slot the same cycle, so a push into a full FIFO is still taken
    assign wr    = push && (!full || rd);
    assign dout  = mem[rd_ptr];
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= count + CNT_W'(wr) - CNT_W'(rd);
        end
    always_ff @(posedge clock)
        if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/pcie_pio_regs.sv
// pcie_pio_regs: PIO register bank with control/status words, MSI interrupt controller
// and a completion FIFO towards pcie_tx.
module pcie_pio_regs #(
    parameter int          NIRQ       = 4,
    parameter int          NSTAT      = 4,
    parameter int          NCTRL      = 4,
    parameter int          CW         = 16,
    parameter int          CPL_DEPTH  = 4,
    parameter logic [63:0] CTRL_RESET = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write_valid,
    input  logic                  read_valid,
    input  logic                  completion_valid,
    input  logic [12:0]           address,
    input  logic [63:0]           data,
    input  logic [23:0]           rid_tag,
    output logic                  rc_valid,
    input  logic                  rc_ready,
    output logic [23:0]           rc_rid_tag,
    output logic [3:0]            rc_lower_addr,
    output logic [63:0]           rc_data,
    input  logic [64*NSTAT-1:0]   status_in,
    output logic [64*NCTRL-1:0]   ctrl_out,
    output logic [NCTRL-1:0]      ctrl_write,
    input  logic [NIRQ-1:0]       irq_in,
    output logic                  cfg_interrupt,
    output logic [7:0]            cfg_interrupt_di,
    input  logic                  cfg_interrupt_rdy
);
    import pcie_pio_pkg::*;
    localparam int PW = NIRQ > 1 ? $clog2(NIRQ) : 1;
    localparam int FW = $clog2(CPL_DEPTH) + 1;
    logic [63:0]      scratch, rd_val;
    logic [CW-1:0]    rd_cnt, wr_cnt, cpl_cnt;
    logic [NIRQ-1:0]  pending, mask, sent, eligible, w1c, force_v;
    logic             overflow, rd_pend, in_stat, in_ctrl, pop, drop;
    logic             fifo_full, fifo_empty, grant, ack;
    logic [FW-1:0]    fifo_count;
    logic [CPL_W-1:0] rd_ent, head;
    logic [63:0]      ctrl [8];
    logic [63:0]      stat_w [8];
    logic [7:0]       ctrl_we;
    logic [PW-1:0]    ptr, gidx, gnt_idx;
    irq_state_t       state, state_next;
    for (genvar i = 0; i < 8; i++) begin : g_stat
        if (i < NSTAT) begin : g_on
            assign stat_w[i] = status_in[64*i +: 64];
        end else begin : g_off
            assign stat_w[i] = '0;
        end
    end
    for (genvar i = 0; i < NCTRL; i++) begin : g_ctrl
        assign ctrl_out[64*i +: 64] = ctrl[i];
    end
    assign in_stat  = address >= ADDR_STATUS_BASE && address < ADDR_STATUS_BASE + 13'(NSTAT);
    assign in_ctrl  = address >= ADDR_CTRL_BASE && address < ADDR_CTRL_BASE + 13'(NCTRL);
    assign ctrl_we  = (write_valid && in_ctrl) ? 8'(1) << address[2:0] : 8'h0;
    assign w1c      = (write_valid && address == ADDR_PENDING) ? data[NIRQ-1:0] : '0;
    assign force_v  = (write_valid && address == ADDR_FORCE) ? data[NIRQ-1:0] : '0;
    assign eligible = pending & mask & ~sent;
    assign rd_val = address == ADDR_SCRATCH  ? scratch :
                    address == ADDR_RD_CNT   ? 64'(rd_cnt) :
                    address == ADDR_WR_CNT   ? 64'(wr_cnt) :
                    address == ADDR_CPL_CNT  ? 64'(cpl_cnt) :
                    address == ADDR_PENDING  ? 64'(pending) :
                    address == ADDR_MASK     ? 64'(mask) :
                    address == ADDR_FORCE    ? 64'h0 :
                    address == ADDR_OVERFLOW ? 64'(overflow) :
                    in_stat                  ? stat_w[address[2:0]] :
                    in_ctrl                  ? ctrl[address[2:0]] :
                                               {19'b0, address, FILLER};
    assign pop  = rc_ready && !fifo_empty;
    assign drop = rd_pend && fifo_full && !pop;
    assign rc_valid = fifo_count != '0;
    assign {rc_rid_tag, rc_lower_addr, rc_data} = head;
    pcie_cpl_fifo #(.W(CPL_W), .DEPTH(CPL_DEPTH)) u_fifo (
        .clock(clock), .reset(reset), .push(rd_pend), .pop(pop), .din(rd_ent),
        .dout(head), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
    );
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            scratch    <= '0;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            cpl_cnt    <= '0;
            pending    <= '0;
            mask       <= '0;
            overflow   <= 1'b0;
            ctrl_write <= '0;
            rd_pend    <= 1'b0;
            rd_ent     <= '0;
            for (int i = 0; i < 8; i++) ctrl[i] <= CTRL_RESET;
        end else begin
            rd_cnt     <= rd_cnt + CW'(read_valid);
            wr_cnt     <= wr_cnt + CW'(write_valid);
            cpl_cnt    <= cpl_cnt + CW'(completion_valid);
            if (write_valid && address == ADDR_SCRATCH) scratch <= data;
            if (write_valid && address == ADDR_MASK) mask <= data[NIRQ-1:0];
            // irq_in is ORed after the W1C so a same-cycle set wins
            pending    <= (pending & ~w1c) | force_v | irq_in;
            overflow   <= (overflow && !(write_valid && address == ADDR_OVERFLOW)) || drop;
            for (int i = 0; i < 8; i++) if (ctrl_we[i]) ctrl[i] <= data;
            ctrl_write <= ctrl_we[NCTRL-1:0];
            rd_pend    <= read_valid;
            rd_ent     <= {rid_tag, address[3:0], rd_val};
        end
    // round-robin: scan from the highest offset down so the nearest index at/after ptr wins
    always_comb begin
        gnt_idx = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            int j;
            j = int'(ptr) + k;
            j = j >= NIRQ ? j - NIRQ : j;
            if (eligible[PW'(j)]) gnt_idx = PW'(j);
        end
    end
    always_comb begin
        grant      = state == IRQ_IDLE && |eligible;
        ack        = state == IRQ_REQ && cfg_interrupt_rdy;
        state_next = grant ? IRQ_REQ : ack ? IRQ_GAP : state == IRQ_GAP ? IRQ_IDLE : state;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IRQ_IDLE;
            gidx  <= '0;
            ptr   <= '0;
            sent  <= '0;
        end else begin
            state <= state_next;
            if (grant) gidx <= gnt_idx;
            if (ack) ptr <= gidx == PW'(NIRQ - 1) ? '0 : gidx + 1'b1;
            sent  <= (sent | (ack ? NIRQ'(1) << gidx : '0)) & pending;
        end
    assign cfg_interrupt    = state == IRQ_REQ;
    assign cfg_interrupt_di = 8'(gidx);
endmodule
